// File: rtl/r3_shadow_checker_pkg.sv
// Shared defaults and the retired-instruction trace entry layout used by the shadow checker and trace monitors.
// Pure declarations: no latency, no backpressure.
package r3_shadow_checker_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_REGS_DEF   = 32;
  localparam int ADDR_WIDTH_DEF = $clog2(NUM_REGS_DEF);

  typedef struct packed {
    logic                      valid;
    logic                      wben;
    logic [ADDR_WIDTH_DEF-1:0] wbreg;
    logic [DATA_WIDTH_DEF-1:0] wbdata;
    logic [31:0]               pc;
    logic [31:0]               insn;
  } trace_t;

endpackage

// File: rtl/r3_shadow_checker_shadow_regfile.sv
// Register array with one synchronous write port and two combinational read ports that bypass the write in flight.
// Write lands on the next rising edge, reads are 0-cycle; no backpressure.
module shadow_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  output logic [DATA_WIDTH-1:0] rd0_data,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic [DATA_WIDTH-1:0] rd1_data
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  rd0_ok;
  logic                  rd1_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Indices past the last register read as zero rather than X.
  assign rd0_ok = ({1'b0, rd0_addr} < (ADDR_WIDTH+1)'(NUM_REGS));
  assign rd1_ok = ({1'b0, rd1_addr} < (ADDR_WIDTH+1)'(NUM_REGS));

  always_comb begin
    rd0_data = '0;
    rd1_data = '0;
    if (wr_en && (wr_addr == rd0_addr)) rd0_data = wr_data;
    else if (rd0_ok)                    rd0_data = regs[rd0_addr];
    if (wr_en && (wr_addr == rd1_addr)) rd1_data = wr_data;
    else if (rd1_ok)                    rd1_data = regs[rd1_addr];
  end

endmodule

// File: rtl/r3_shadow_checker.sv
// Shadow copy of a core's GPRs rebuilt from trace write-backs; exposes the watched register and a debug read port.
// Reads are 0-cycle with write-through bypass; no handshake, every valid trace cycle is consumed.
module r3_shadow_checker
  import r3_shadow_checker_pkg::*;
#(
  parameter int DATA_WIDTH         = DATA_WIDTH_DEF,
  parameter int NUM_REGS           = NUM_REGS_DEF,
  parameter int ADDR_WIDTH         = $clog2(NUM_REGS),
  parameter int WATCH_REG          = 3,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] r3
);

  localparam logic [ADDR_WIDTH-1:0] WATCH_IDX = ADDR_WIDTH'(WATCH_REG);
  localparam logic                  ZERO_HW   = (ZERO_REG_HARDWIRED != 0);

  logic                  addr_ok;
  logic                  zero_drop;
  logic                  wr;
  logic [DATA_WIDTH-1:0] rf_watch;
  logic [DATA_WIDTH-1:0] rf_dbg;

  // Dropped writes never reach the array, so they can never be bypassed either.
  assign addr_ok   = ({1'b0, addr} < (ADDR_WIDTH+1)'(NUM_REGS));
  assign zero_drop = ZERO_HW && (addr == '0);
  assign wr        = valid & we & ~rst & addr_ok & ~zero_drop;

  shadow_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr),
    .wr_addr  (addr),
    .wr_data  (data),
    .rd0_addr (WATCH_IDX),
    .rd0_data (rf_watch),
    .rd1_addr (rd_addr),
    .rd1_data (rf_dbg)
  );

  assign r3      = rst ? '0 : rf_watch;
  assign rd_data = (rst || (ZERO_HW && (rd_addr == '0))) ? '0 : rf_dbg;

endmodule

// File: tb/tb_r3_shadow_checker.sv
// Scoreboard bench for r3_shadow_checker: expected reads are queued as each cycle is driven and popped at the falling edge.
module tb_r3_shadow_checker;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] r3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mdl [NR];
  string         tag_q [$];
  logic [DW-1:0] r3_q  [$];
  logic [DW-1:0] rd_q  [$];

  always #5 clk = ~clk;

  r3_shadow_checker dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .we      (we),
    .addr    (addr),
    .data    (data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .r3      (r3)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    logic w;
    w = valid && we && !rst && (addr != 0);
    if (rst || a == 0) return '0;
    if (w && addr == a) return data;
    return mdl[a];
  endfunction

  // One trace cycle: drive after the rising edge, compare at the falling edge, then commit to the model.
  task automatic step(input string tag, input logic r, input logic v, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [AW-1:0] ra);
    @(posedge clk);
    #1;
    rst = r; valid = v; we = w; addr = a; data = d; rd_addr = ra;
    tag_q.push_back(tag);
    r3_q.push_back(exp_read(5'd3));
    rd_q.push_back(exp_read(ra));
    @(negedge clk);
    if (tag_q.size() == 0) begin
      chk("scoreboard_empty", 32'(tag_q.size()), 32'd1);
    end else begin
      string t;
      t = tag_q.pop_front();
      chk({t, "/r3"}, r3, r3_q.pop_front());
      chk({t, "/rd"}, rd_data, rd_q.pop_front());
    end
    if (rst) begin
      for (int i = 0; i < NR; i++) mdl[i] = '0;
    end else if (valid && we && addr != 0) begin
      mdl[addr] = data;
    end
  endtask

  task automatic idle(input string tag, input int n, input logic [AW-1:0] ra);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, ra);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mdl[i] = 32'hA5A5_0000 | i;

    step("reset", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
    step("reset", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd3);
    for (int i = 0; i < NR; i++) step("idle_scan", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'(i));

    step("wr_r3", 1'b0, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 5'd3);
    idle("r3_hold", 3, 5'd3);

    step("wr_r4", 1'b0, 1'b1, 1'b1, 5'd4, 32'h1234_5678, 5'd4);
    idle("r4_hold", 2, 5'd4);

    step("we_low", 1'b0, 1'b1, 1'b0, 5'd3, 32'd0, 5'd3);
    step("valid_low", 1'b0, 1'b0, 1'b1, 5'd3, 'x, 5'd3);
    idle("gated_hold", 2, 5'd3);

    step("wr_r0", 1'b0, 1'b1, 1'b1, 5'd0, 32'd5, 5'd0);
    idle("r0_hold", 2, 5'd0);

    step("b2b_1", 1'b0, 1'b1, 1'b1, 5'd3, 32'd1, 5'd3);
    step("b2b_2", 1'b0, 1'b1, 1'b1, 5'd3, 32'd2, 5'd3);
    step("b2b_3", 1'b0, 1'b1, 1'b1, 5'd3, 32'd3, 5'd4);
    idle("b2b_hold", 2, 5'd3);

    step("rst_wr", 1'b1, 1'b1, 1'b1, 5'd3, 32'd9, 5'd3);
    idle("post_rst", 2, 5'd3);
    step("post_rst_r4", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd4);
    step("wr_after_rst", 1'b0, 1'b1, 1'b1, 5'd3, 32'd7, 5'd3);
    idle("r3_7_hold", 2, 5'd3);

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 5'd3 : 5'($urandom), $urandom,
           ($urandom_range(0, 2) == 0) ? 5'd3 : 5'($urandom));
    end

    chk("scoreboard_drain", 32'(tag_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
